// File: rtl/pc_control.sv
// PC and condition-flag unit for the 16-bit single-cycle core: holds pc and the
// stored {N,V,Z}, evaluates B/BR conditions and produces next pc and sticky halt.
module pc_control #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic [2:0]  alu_flags,
  input  logic [15:0] reg_rs,
  input  logic        stall,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [2:0]  flags,
  output logic        branch_taken,
  output logic        halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_nxt;
  logic [2:0]  flags_nxt;
  logic [3:0]  opcode;
  logic [2:0]  ccc;
  logic        cond_met;
  logic        is_branch;
  logic        retire;
  logic signed [15:0] b_offset;

  // Condition codes against stored {N,V,Z}.
  function automatic logic eval_cond(input logic [2:0] cc, input logic [2:0] f);
    logic n, v, z;
    n = f[2];
    v = f[1];
    z = f[0];
    case (cc)
      3'b000:  eval_cond = !z;
      3'b001:  eval_cond = z;
      3'b010:  eval_cond = !z && !n;
      3'b011:  eval_cond = n;
      3'b100:  eval_cond = z || (!z && !n);
      3'b101:  eval_cond = n || z;
      3'b110:  eval_cond = v;
      default: eval_cond = 1'b1;
    endcase
  endfunction

  assign opcode    = instr[15:12];
  assign ccc       = instr[11:9];
  assign pc_plus2  = pc + 16'd2;
  assign halted    = (state == HALT);
  assign is_branch = (opcode == OP_B) || (opcode == OP_BR);
  assign cond_met  = eval_cond(ccc, flags);
  assign retire    = (state == RUN) && !stall;

  assign branch_taken = is_branch && cond_met && !halted;
  // Word offset: sign-extended 9-bit immediate scaled by 2.
  assign b_offset     = {{6{instr[8]}}, instr[8:0], 1'b0};

  always_comb begin
    pc_nxt    = pc;
    flags_nxt = flags;
    state_nxt = state;
    if (retire) begin
      if (opcode == OP_HLT) begin
        state_nxt = HALT;
      end else if (branch_taken && opcode == OP_B) begin
        pc_nxt = pc_plus2 + b_offset;
      end else if (branch_taken && opcode == OP_BR) begin
        pc_nxt = reg_rs & 16'hFFFE;
      end else begin
        pc_nxt = pc_plus2;
      end

      case (opcode)
        OP_ADD, OP_SUB:                 flags_nxt = alu_flags;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_nxt = {flags[2:1], alu_flags[0]};
        default:                        flags_nxt = flags;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
      flags <= 3'b000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      flags <= flags_nxt;
    end
  end

endmodule

// File: doc/pc_control.md
# pc_control

Program-counter and condition-flag unit for the 16-bit single-cycle core. Holds the architectural PC and the N/V/Z flag register. Consumes the ALU's per-instruction flag outputs and evaluates the branch condition codes of B and BR against the stored flags. Produces the next PC, the PCS link value and the sticky halt indication.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr  input  16  instruction currently fetched at pc; opcode = instr[15:12].
- alu_flags  input  3  {N,V,Z} from the ALU for the current instruction.
- reg_rs  input  16  register-file read data for BR's source register.
- stall  input  1  when high, PC, flags and halt state hold.
- pc  output  16  current PC (instruction-fetch address).
- pc_plus2  output  16  pc + 2, modulo 2^16; PCS write-back value.
- flags  output  3  stored {N,V,Z}.
- branch_taken  output  1  combinational; high when the current B/BR condition is met.
- halted  output  1  sticky halt; high once HLT has retired.

## Operation
- Opcodes: ADD 0000, SUB 0001, XOR 0011, SLL 0100, SRA 0101, ROR 0110, B 1100, BR 1101, PCS 1110, HLT 1111. All other opcodes are non-control, non-flag-writing.
- Flag write on the retiring edge:
  - ADD, SUB: write N, V and Z from alu_flags.
  - XOR, SLL, SRA, ROR: write Z only; N and V hold.
  - All other opcodes: flags hold.
- Condition code ccc = instr[11:9], evaluated against the stored flags, i.e. the value before this instruction's edge:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GE: Z=1, or Z=0 and N=0.
  - 101 LE: N=1 or Z=1.
  - 110 OV: V=1.
  - 111 always.
- branch_taken is high only for B/BR when the condition is true; it is 0 for other opcodes and while halted.
- Next PC:
  - B taken: pc_plus2 + (sign_extend(instr[8:0]) << 1), 16-bit wrap.
  - BR taken: reg_rs & 16'hFFFE (bit 0 forced to 0).
  - HLT: pc holds.
  - Otherwise: pc_plus2.
- States:
  - RUN: normal operation.
  - HALT: entered on the edge where HLT retires with stall=0. pc, flags and halted freeze; only reset exits HALT.
- stall=1 in RUN: no register changes. branch_taken is still driven combinationally.

## Timing
- Single-cycle: every retiring instruction updates pc and flags on the same rising edge. A branch sees flags written by earlier instructions only.
- Reset (asynchronous assert, synchronous-safe deassert): pc=RESET_PC, flags=3'b000, halted=0, state=RUN. pc_plus2=RESET_PC+2; branch_taken follows instr.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- halted rises on the first edge after HLT is presented with stall=0. pc stays at the HLT address.
- Wrap-around: pc=16'hFFFE with a non-branch gives next pc=16'h0000. Branch targets wrap modulo 2^16.
- HLT with stall=1: no halt until stall drops.

## Test plan
- Reset: rst_n=0 mid-run -> pc=0000, flags=000, halted=0 without a clock edge; release, run 3 NOPs (opcode 1000) -> pc=0006.
- Flag write rules: ADD with alu_flags=110 -> flags=110. Then XOR with alu_flags=001 -> flags=111. Then LLB with alu_flags=000 -> flags=111.
- B conditions: at pc=0010, flags Z=1, B ccc=001 imm=9'h003 -> branch_taken=1, next pc=0018. Same with ccc=000 -> pc=0012. imm=9'h1FF, ccc=111 -> pc=0010.
- BR and PCS: BR ccc=111 with reg_rs=1235 -> pc=1234. PCS at pc=0040 -> pc_plus2=0042, pc=0042.
- Wrap: pc=FFFE with a NOP -> pc=0000. pc=FFFC, B ccc=111, imm=9'h002 -> pc=0002.
- Halt and stall: stall=1 with ADD -> pc and flags unchanged. HLT at 0020 with stall=0 -> halted=1, pc=0020 for 10 cycles with any instr. rst_n pulse -> halted=0, pc=0000.
